// File: rtl/mux4_way.sv
// 4:1 WIDTH-bit selector with a combinational output and an enable-loaded registered copy.
// Define MUX4_WAY_PARITY_EN to add out_par, the XOR reduction of the value loaded into out_q.
module mux4_way #(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] out_q,
  output logic [1:0]       sel_q
`ifdef MUX4_WAY_PARITY_EN
  ,
  output logic             out_par
`endif
);

  logic [WIDTH-1:0] out_d;
  logic [1:0]       sel_d;

  // Nested conditionals keep plain Verilog X-merging when sel carries X/Z.
  assign out = sel[1] ? (sel[0] ? d : c) : (sel[0] ? b : a);

  always_comb begin
    out_d = out_q;
    sel_d = sel_q;
    if (en) begin
      out_d = out;
      sel_d = sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      sel_q <= 2'b00;
    end else begin
      out_q <= out_d;
      sel_q <= sel_d;
    end
  end

`ifdef MUX4_WAY_PARITY_EN
  logic par_d;
  logic par_q;

  always_comb begin
    par_d = par_q;
    if (en) par_d = ^out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  assign out_par = par_q;
`endif

endmodule

// File: tb/tb_mux4_way.sv
// Directed bench for mux4_way: a WIDTH=1 and a WIDTH=8 instance sharing clock and reset.
module tb_mux4_way;

  logic clk;
  logic rst_n;

  logic       a1, b1, c1, d1, en1;
  logic [1:0] sel1;
  logic       out1, out_q1;
  logic [1:0] sel_q1;

  logic [7:0] a8, b8, c8, d8;
  logic [7:0] out8, out_q8;
  logic [1:0] sel8, sel_q8;
  logic       en8;
`ifdef MUX4_WAY_PARITY_EN
  logic       par1, par8;
`endif

  int total = 0;
  int bad   = 0;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux4_way #(.WIDTH(1)) u_w1 (
    .out(out1), .a(a1), .b(b1), .c(c1), .d(d1), .sel(sel1),
    .clk(clk), .rst_n(rst_n), .en(en1), .out_q(out_q1), .sel_q(sel_q1)
`ifdef MUX4_WAY_PARITY_EN
    , .out_par(par1)
`endif
  );

  mux4_way #(.WIDTH(8)) u_w8 (
    .out(out8), .a(a8), .b(b8), .c(c8), .d(d8), .sel(sel8),
    .clk(clk), .rst_n(rst_n), .en(en8), .out_q(out_q8), .sel_q(sel_q8)
`ifdef MUX4_WAY_PARITY_EN
    , .out_par(par8)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive1(input logic a, input logic b, input logic c, input logic d, input logic [1:0] s);
    a1 = a; b1 = b; c1 = c; d1 = d; sel1 = s;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp8 [4];

  initial begin
    rst_n = 1'b0; en1 = 1'b0; en8 = 1'b0;
    a8 = 8'h11; b8 = 8'h22; c8 = 8'h33; d8 = 8'h44; sel8 = 2'b00;
    drive1(0, 0, 0, 0, 2'b00);

    // Combinational path, exercised while reset is held (out must not care).
    for (int s = 0; s < 4; s++) begin
      drive1(0, 0, 0, 0, 2'(s));
      check($sformatf("zero_sel%0d", s), 32'(out1), 32'd0);
    end
    drive1(0, 1, 1, 0, 2'b10); check("p1_sel10", 32'(out1), 32'd1);
    drive1(0, 1, 1, 0, 2'b11); check("p1_sel11", 32'(out1), 32'd0);
    drive1(0, 1, 1, 0, 2'b01); check("p1_sel01", 32'(out1), 32'd1);
    drive1(0, 1, 1, 0, 2'b00); check("p1_sel00", 32'(out1), 32'd0);
    drive1(1, 0, 0, 1, 2'b01); check("p2_sel01", 32'(out1), 32'd0);
    drive1(1, 0, 0, 1, 2'b10); check("p2_sel10", 32'(out1), 32'd0);
    drive1(1, 0, 0, 1, 2'b11); check("p2_sel11", 32'(out1), 32'd1);
    drive1(1, 0, 1, 0, 2'b00); check("p3_sel00", 32'(out1), 32'd1);
    drive1(1, 0, 1, 0, 2'b10); check("p3_sel10", 32'(out1), 32'd1);
    for (int s = 0; s < 4; s++) begin
      drive1(1, 1, 1, 1, 2'(s));
      check($sformatf("ones_sel%0d", s), 32'(out1), 32'd1);
    end
    drive1(0, 1, 1, 1, 2'b10); check("unsel_a", 32'(out1), 32'd1);
    drive1(0, 0, 1, 1, 2'b10); check("unsel_b", 32'(out1), 32'd1);
    drive1(0, 0, 1, 0, 2'b10); check("unsel_d", 32'(out1), 32'd1);

    exp8[0] = 8'h11; exp8[1] = 8'h22; exp8[2] = 8'h33; exp8[3] = 8'h44;
    for (int s = 0; s < 4; s++) begin
      sel8 = 2'(s);
      #1;
      check($sformatf("w8_sel%0d", s), 32'(out8), 32'(exp8[s]));
    end
    sel8 = 2'b10; a8 = 8'hff; d8 = 8'h00;
    #1;
    check("w8_unsel", 32'(out8), 32'h33);
    a8 = 8'h11; d8 = 8'h44;

    // Clock edges under reset with en=1 must be ignored.
    drive1(0, 0, 0, 1, 2'b11);
    en1 = 1'b1;
    tick; tick;
    check("rst_out_q", 32'(out_q1), 32'd0);
    check("rst_sel_q", 32'(sel_q1), 32'd0);

    // First load after release.
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    check("load_out_q", 32'(out_q1), 32'd1);
    check("load_sel_q", 32'(sel_q1), 32'd3);

    // Hold with en=0.
    @(negedge clk);
    en1 = 1'b0;
    drive1(0, 0, 0, 0, 2'b00);
    tick;
    check("hold_out_q", 32'(out_q1), 32'd1);
    check("hold_sel_q", 32'(sel_q1), 32'd3);

    // One-cycle latency on a new value.
    @(negedge clk);
    en1 = 1'b1;
    drive1(0, 0, 1, 0, 2'b10);
    check("pre_edge_out_q", 32'(out_q1), 32'd1);
    tick;
    check("lat_out_q", 32'(out_q1), 32'd1);
    check("lat_sel_q", 32'(sel_q1), 32'd2);

    // Async reset between edges clears immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_q", 32'(out_q1), 32'd0);
    check("async_sel_q", 32'(sel_q1), 32'd0);
    check("out_in_rst", 32'(out1), 32'd1);
    tick;
    check("rst_edge_out_q", 32'(out_q1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive1(0, 1, 0, 0, 2'b01);
    tick;
    check("reload_out_q", 32'(out_q1), 32'd1);
    check("reload_sel_q", 32'(sel_q1), 32'd1);

    // Width-8 registered path and parity.
    @(negedge clk);
    en8 = 1'b1; sel8 = 2'b10;
    tick;
    check("w8_q_33", 32'(out_q8), 32'h33);
    check("w8_selq_10", 32'(sel_q8), 32'd2);
`ifdef MUX4_WAY_PARITY_EN
    check("w8_par_33", 32'(par8), 32'd0);
`endif
    @(negedge clk);
    c8 = 8'h31;
    tick;
    check("w8_q_31", 32'(out_q8), 32'h31);
`ifdef MUX4_WAY_PARITY_EN
    check("w8_par_31", 32'(par8), 32'd1);
`endif
    @(negedge clk);
    en8 = 1'b0; sel8 = 2'b11;
    tick;
    check("w8_hold", 32'(out_q8), 32'h31);
    check("w8_hold_sel", 32'(sel_q8), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux4_way.md
Name: mux4_way

Overview:
- 4-input selector: routes one of four WIDTH-bit data inputs (a, b, c, d) to the output under a 2-bit select.
- Primary path is purely combinational, zero latency.
- Also provides a registered copy of the selected value, with a load enable, for pipelined consumers.
- Leaf datapath primitive, used wherever a 4:1 choice is needed (ALU operand steering, register-file read ports).

Parameters:
- WIDTH, 1, data width in bits of a, b, c, d, out and out_q.

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst_n  input  1  asynchronous active-low reset.
- out  output  WIDTH  combinational selected data.
- a  input  WIDTH  data, selected when sel=2'b00.
- b  input  WIDTH  data, selected when sel=2'b01.
- c  input  WIDTH  data, selected when sel=2'b10.
- d  input  WIDTH  data, selected when sel=2'b11.
- sel  input  2  select code.
- en  input  1  load enable for out_q and sel_q.
- out_q  output  WIDTH  registered selected data.
- sel_q  output  2  registered select code that produced out_q.

Port order for positional instantiation: out, a, b, c, d, sel, clk, rst_n, en, out_q, sel_q.

Behaviour:
- out = a when sel=00, b when 01, c when 10, d when 11.
- out is a bitwise, purely combinational function of the inputs. No clock or reset dependency.
- out settles within the same delta/time step as any change on a, b, c, d or sel.
- out does not depend on unselected inputs. Toggling an unselected input never changes out.
- Registered path: on rising clk with en=1, out_q <= out and sel_q <= sel. With en=0, both hold.
- Reset: rst_n low forces out_q = 0 and sel_q = 2'b00 immediately, independent of clk.
- While rst_n is low, clock edges are ignored.
- First load after deassertion occurs at the first rising edge with rst_n=1 and en=1.
- out keeps operating normally during reset.
- Reset asserted mid-operation discards the held value. out_q and sel_q read 0 until the next enabled edge.
- Registered path latency: 1 cycle from sel/data change to out_q.
- Widths: all data ports are exactly WIDTH bits. No extension or truncation.
- sel containing X/Z: out follows standard Verilog conditional semantics (bits where all candidate inputs agree resolve; others are X). No special handling.

Optional Feature:
- Macro: MUX4_WAY_PARITY_EN.
- When defined:
  - Adds output port out_par (1 bit), appended after sel_q.
  - out_par is a register equal to the XOR reduction of the value loaded into out_q.
  - Updated on the same enabled edge as out_q. Reset value 0.
- When undefined:
  - Port is absent; no parity logic is generated.
  - All other behaviour is identical.

Test Plan:
- WIDTH=1, all inputs 0, sel swept 00..11 -> out=0 for every code.
- a=0 b=1 c=1 d=0: sel=10 -> out=1; sel=11 -> out=0; sel=01 -> out=1; sel=00 -> out=0.
- a=1 b=0 c=0 d=1: sel=01 -> 0, sel=10 -> 0, sel=11 -> 1. Then a=1 c=1 b=d=0: sel=00 -> 1, sel=10 -> 1.
- All inputs 1: every sel -> out=1. Toggle an unselected input with sel fixed -> out unchanged.
- Registered path:
  - Hold rst_n=0 -> out_q=0, sel_q=00.
  - Release; sel=11, d=1, en=1, one edge -> out_q=1, sel_q=11.
  - en=0, change sel/data -> out_q holds.
  - Assert rst_n between edges -> out_q=0 immediately.
- WIDTH=8, a=8'h11 b=8'h22 c=8'h33 d=8'h44:
  - sel 00..11 -> out 11, 22, 33, 44.
  - With MUX4_WAY_PARITY_EN, after loading 8'h33 -> out_par=0; after loading 8'h31 -> out_par=1.
